// File: rtl/vid_pkg.sv
// vid_pkg: shared constants and types for the video scan-out engine.
// Bus commands, register indices, fetch FSM states and pixel modes.
package vid_pkg;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd1;
  localparam logic [2:0] CMD_WRREG = 3'd2;
  localparam logic [2:0] CMD_RDATA = 3'd5;

  localparam logic [1:0] REG_BASE   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_FWORDS = 2'd2;
  localparam logic [1:0] REG_UFCLR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE, REQ, CMD, DATA
  } fetch_state_t;

  typedef enum logic {
    MODE_RGB32 = 1'b0,
    MODE_GRAY8 = 1'b1
  } px_mode_t;

  function automatic logic [1:0] burst_code(input int n);
    case (n)
      1:       return 2'b00;
      2:       return 2'b01;
      4:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/vid_fifo.sv
// vid_fifo: synchronous pixel-word FIFO with flush and fill count.
// Ports: push/wdata in, pop/rdata out, flush clears, empty/full/fill status.
module vid_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      fill
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             do_push, do_pop;

  assign empty = (fill == '0);
  assign full  = (fill == (AW+1)'(DEPTH));
  // a push into a full FIFO is fine when a pop frees a slot the same cycle
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp   <= '0;
      rp   <= '0;
      fill <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      fill <= fill + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !(reset || flush)) mem[wp] <= wdata;
  end

endmodule

// File: rtl/vid_fetch_px.sv
// vid_fetch_px: frame-buffer burst fetcher and pixel scan-out engine.
// Bus side: sel/cmd/len/addrdata in, req/len/addrdata/cmd/tar out, ackin; video: timing in, RGB + underflow out.
module vid_fetch_px
  import vid_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter int          BURST_LEN  = 8,
  parameter int          LOW_WM     = 4,
  parameter logic [3:0]  TARGET_ID  = 4'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        selin,
  input  logic [2:0]  cmdin,
  input  logic [1:0]  lenin,
  input  logic [31:0] addrdatain,
  output logic [1:0]  reqout,
  output logic [1:0]  lenout,
  output logic [31:0] addrdataout,
  output logic [2:0]  cmdout,
  output logic [3:0]  reqtar,
  input  logic        ackin,
  input  logic        enable,
  input  logic        hsync,
  input  logic        hblank,
  input  logic        vsync,
  input  logic        vblank,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BURST_LEN);
  localparam logic [BW:0]   BL_M1 = (BW+1)'(BURST_LEN - 1);
  localparam logic [BW:0]   BL_N  = (BW+1)'(BURST_LEN);
  localparam logic [31:0]   BL32  = 32'(BURST_LEN);
  localparam logic [31:0]   STEP  = 32'(4 * BURST_LEN);
  localparam logic [1:0]    BCODE = burst_code(BURST_LEN);

  fetch_state_t state, nstate;
  px_mode_t     mode;
  logic         fetch_en, vsync_q, fs, wr, rd;
  logic [31:0]  base, fwords, base_nx, fw_nx;
  logic [31:0]  cur_addr, words_left;
  logic [BW:0]  cnt, keep;
  logic         drop;
  logic         push, pop, act, empty, full;
  logic [31:0]  head;
  logic [AW:0]  fill;
  logic [1:0]   bidx;
  logic [7:0]   gray;
  logic         room, urgent;
  logic         unused_sink;

  assign unused_sink = &{1'b0, hsync, full};

  assign wr = selin && cmdin == CMD_WRREG;
  assign rd = selin && cmdin == CMD_RDATA;
  assign fs = vsync & ~vsync_q;

  // a register write on the frame-start edge must feed the reload
  assign base_nx = (wr && lenin == REG_BASE) ?
                   {addrdatain[31:2], 2'b00} : base;
  assign fw_nx   = (wr && lenin == REG_FWORDS) ? addrdatain : fwords;

  assign room   = fill <= (AW+1)'(FIFO_DEPTH - BURST_LEN);
  assign urgent = fill < (AW+1)'(LOW_WM);

  always_ff @(posedge clk) begin
    if (reset) begin
      base     <= '0;
      fwords   <= '0;
      fetch_en <= 1'b0;
      mode     <= MODE_RGB32;
      vsync_q  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (wr) begin
        unique case (lenin)
          REG_BASE:   base   <= base_nx;
          REG_CTRL: begin
            fetch_en <= addrdatain[0];
            mode     <= px_mode_t'(addrdatain[1]);
          end
          REG_FWORDS: fwords <= addrdatain;
          REG_UFCLR:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (fetch_en && words_left != '0 && !fs && room)
              nstate = REQ;
      REQ:  if (ackin) nstate = CMD;
      CMD:  nstate = DATA;
      DATA: if (rd && cnt == BL_M1) nstate = IDLE;
    endcase
  end

  always_comb begin
    reqout      = 2'b00;
    lenout      = 2'b00;
    addrdataout = '0;
    cmdout      = CMD_NOP;
    reqtar      = '0;
    unique case (state)
      REQ: begin
        reqout = urgent ? 2'b10 : 2'b01;
        reqtar = TARGET_ID;
      end
      CMD: begin
        cmdout      = CMD_READ;
        addrdataout = cur_addr;
        lenout      = BCODE;
        reqtar      = TARGET_ID;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr   <= '0;
      words_left <= '0;
      cnt        <= '0;
      keep       <= '0;
      drop       <= 1'b0;
    end else begin
      if (state == CMD) begin
        cur_addr   <= cur_addr + STEP;
        words_left <= (words_left >= BL32) ? words_left - BL32 : '0;
        // words past the frame end are still read but not stored
        keep       <= (words_left >= BL32) ? BL_N : words_left[BW:0];
        cnt        <= '0;
        drop       <= 1'b0;
      end else if (state == DATA && rd) begin
        cnt <= cnt + (BW+1)'(1);
      end
      if (fs) begin
        cur_addr   <= base_nx;
        words_left <= fw_nx;
        // the in-flight burst belongs to the old frame
        if (state == CMD || state == DATA) drop <= 1'b1;
      end
    end
  end

  assign push = state == DATA && rd && !drop && cnt < keep;
  assign act  = enable & ~hblank & ~vblank;
  assign gray = head[{bidx, 3'b000} +: 8];
  assign pop  = act & ~empty & (mode == MODE_RGB32 || bidx == 2'd3);

  vid_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (fs),
    .push  (push),
    .wdata (addrdatain),
    .pop   (pop),
    .rdata (head),
    .empty (empty),
    .full  (full),
    .fill  (fill)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      R         <= '0;
      G         <= '0;
      B         <= '0;
      bidx      <= '0;
      underflow <= 1'b0;
    end else begin
      if (wr && lenin == REG_UFCLR) underflow <= 1'b0;
      {R, G, B} <= '0;
      if (act) begin
        if (empty) begin
          underflow <= 1'b1;
        end else if (mode == MODE_RGB32) begin
          {R, G, B} <= head[23:0];
        end else begin
          {R, G, B} <= {3{gray}};
          bidx      <= bidx + 2'd1;
        end
      end
      if (fs) bidx <= '0;
    end
  end

endmodule

// File: tb/tb_vid_fetch_px.sv
// tb_vid_fetch_px: randomized scoreboard bench for vid_fetch_px.
// Acts as bus slave/memory and display timing source; models FIFO as a queue.
module tb_vid_fetch_px;
  import vid_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        selin;
  logic [2:0]  cmdin;
  logic [1:0]  lenin;
  logic [31:0] addrdatain;
  logic [1:0]  reqout, lenout;
  logic [31:0] addrdataout;
  logic [2:0]  cmdout;
  logic [3:0]  reqtar;
  logic        ackin, enable, hsync, hblank, vsync, vblank;
  logic [7:0]  R, G, B;
  logic        underflow;

  always #5 clk = ~clk;

  vid_fetch_px dut (
    .clk(clk), .reset(reset), .selin(selin), .cmdin(cmdin),
    .lenin(lenin), .addrdatain(addrdatain), .reqout(reqout),
    .lenout(lenout), .addrdataout(addrdataout), .cmdout(cmdout),
    .reqtar(reqtar), .ackin(ackin), .enable(enable), .hsync(hsync),
    .hblank(hblank), .vsync(vsync), .vblank(vblank),
    .R(R), .G(G), .B(B), .underflow(underflow)
  );

  typedef struct packed {
    logic [7:0] r, g, b;
    logic       uf;
  } px_t;

  px_t sbq[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  mon_on = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'h3c5a, ~a[15:0]} ^ 32'h0012_3400;
  endfunction

  // reference model state
  logic [31:0] m_q[$];
  int          m_bi = 0;
  bit          m_mode = 0, m_uf = 0;
  logic [31:0] m_base = 0, m_fw = 0, m_addr = 0, m_left = 0;
  bit          in_burst = 0, m_drop = 0, exp_cmd = 0, vs_prev = 0;
  int          widx = 0, keep = 0;
  logic [31:0] b_addr = 0;
  bit          wr_pend = 0;
  logic [1:0]  wr_idx;
  logic [31:0] wr_dat;

  task automatic cyc(input int act_pct, input bit vs);
    px_t e;
    bit  act, fs;
    logic [31:0] w, bt;
    @(negedge clk);
    selin = 0; cmdin = CMD_NOP; lenin = 0; addrdatain = 0; ackin = 0;
    fs = vs && !vs_prev;
    enable = !fs && ($urandom_range(99, 0) < act_pct);
    hblank = ($urandom_range(7, 0) == 0);
    hsync  = ($urandom_range(7, 0) == 0);
    vblank = 0;
    act = enable && !hblank && !vblank;
    if (wr_pend && wr_idx == REG_UFCLR) m_uf = 0;
    e = '{r: 8'h0, g: 8'h0, b: 8'h0, uf: 1'b0};
    if (act) begin
      if (m_q.size() == 0) m_uf = 1;
      else begin
        w = m_q[0];
        if (!m_mode) begin
          e.r = w[23:16]; e.g = w[15:8]; e.b = w[7:0];
          void'(m_q.pop_front());
        end else begin
          bt = (w >> (8 * m_bi)) & 32'hff;
          e.r = bt[7:0]; e.g = bt[7:0]; e.b = bt[7:0];
          m_bi++;
          if (m_bi == 4) begin
            m_bi = 0;
            void'(m_q.pop_front());
          end
        end
      end
    end
    if (wr_pend) begin
      selin = 1; cmdin = CMD_WRREG; lenin = wr_idx; addrdatain = wr_dat;
    end else if (in_burst && $urandom_range(2, 0) != 0) begin
      selin = 1; cmdin = CMD_RDATA;
      addrdatain = mem(b_addr + 32'(4 * widx));
      if (!m_drop && widx < keep) m_q.push_back(addrdatain);
      widx++;
      if (widx == 8) in_burst = 0;
    end
    if (cmdout == CMD_READ) begin
      chk("cmd_after_grant", 32'(exp_cmd), 1);
      chk("cmd_addr", addrdataout, m_addr);
      chk("cmd_len", 32'(lenout), 3);
      chk("cmd_tar", 32'(reqtar), 1);
      b_addr = m_addr;
      keep = (m_left >= 8) ? 8 : int'(m_left);
      m_left = (m_left >= 8) ? m_left - 8 : 0;
      m_addr = m_addr + 32;
      in_burst = 1; widx = 0; m_drop = 0;
    end else if (exp_cmd) begin
      chk("cmd_after_grant", 32'(cmdout), 32'(CMD_READ));
    end
    exp_cmd = 0;
    if (reqout != 0) begin
      chk("req_urgency", 32'(reqout), m_q.size() < 4 ? 2 : 1);
      chk("req_tar", 32'(reqtar), 1);
      chk("req_room", 32'(m_q.size() <= 8), 1);
      chk("req_left", 32'(m_left != 0), 1);
      if ($urandom_range(1, 0) == 1) begin
        ackin = 1; exp_cmd = 1;
      end
    end
    if (wr_pend) begin
      unique case (wr_idx)
        REG_BASE:   m_base = {wr_dat[31:2], 2'b00};
        REG_CTRL:   m_mode = wr_dat[1];
        REG_FWORDS: m_fw = wr_dat;
        default: ;
      endcase
      wr_pend = 0;
    end
    vsync = vs;
    vs_prev = vs;
    if (fs) begin
      m_q.delete();
      m_bi = 0;
      m_addr = m_base;
      m_left = m_fw;
      if (in_burst) m_drop = 1;
    end
    e.uf = m_uf;
    sbq.push_back(e);
    mon_on = 1;
  endtask

  task automatic wreg(input logic [1:0] idx, input logic [31:0] d);
    wr_pend = 1; wr_idx = idx; wr_dat = d;
    cyc(0, vs_prev);
  endtask

  task automatic run(input int n, input int pct);
    for (int i = 0; i < n; i++) cyc(pct, 0);
  endtask

  initial begin
    px_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        if (sbq.size() == 0) begin
          chk("sb_empty", 0, 1);
        end else begin
          e = sbq.pop_front();
          chk("pix_r", 32'(R), 32'(e.r));
          chk("pix_g", 32'(G), 32'(e.g));
          chk("pix_b", 32'(B), 32'(e.b));
          chk("underflow", 32'(underflow), 32'(e.uf));
        end
      end
    end
  end

  initial begin
    bit hit;
    reset = 1; selin = 0; cmdin = CMD_NOP; lenin = 0; addrdatain = 0;
    ackin = 0; enable = 0; hsync = 0; hblank = 0; vsync = 0; vblank = 0;
    repeat (3) @(negedge clk);
    chk("rst_reqout", 32'(reqout), 0);
    chk("rst_lenout", 32'(lenout), 0);
    chk("rst_addr", addrdataout, 0);
    chk("rst_cmdout", 32'(cmdout), 32'(CMD_NOP));
    chk("rst_reqtar", 32'(reqtar), 0);
    chk("rst_rgb", {8'h0, R, G, B}, 0);
    chk("rst_uf", 32'(underflow), 0);
    reset = 0;

    wreg(REG_BASE, 32'h0000_1003);
    wreg(REG_FWORDS, 32);
    wreg(REG_CTRL, 1);
    cyc(0, 1); cyc(0, 1);
    run(600, 25);
    wreg(REG_UFCLR, 0);
    run(20, 0);

    wreg(REG_FWORDS, 20);
    wreg(REG_BASE, 32'h0000_4000);
    wreg(REG_CTRL, 3);
    cyc(0, 1);
    run(600, 30);

    cyc(0, 1);
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (in_burst && widx == 3) begin
        cyc(20, 1);
        hit = 1;
      end else begin
        cyc(20, 0);
      end
    end
    chk("vs_midburst_hit", 32'(hit), 1);
    run(400, 20);

    wreg(REG_CTRL, 1);
    wreg(REG_FWORDS, 8);
    cyc(0, 1);
    run(100, 0);
    run(200, 100);
    wreg(REG_UFCLR, 32'hdead);
    run(20, 0);

    @(posedge clk);
    #2;
    mon_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
